// File: rtl/rgb_level_pwm.sv
// rtl/rgb_level_pwm.sv - three-channel BCD level store with period-latched PWM drive
// The encoder steps the selected channel; the PWM shadows pick up new levels only at period ends.
module rgb_level_pwm #(
  parameter int         PRESCALE  = 1,
  parameter logic [7:0] LEVEL_MAX = 8'h99
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc,
  input  logic       dec,
  input  logic       sel,
  output logic [1:0] chan,
  output logic [7:0] level_r,
  output logic [7:0] level_g,
  output logic [7:0] level_b,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b
);

  typedef enum logic [1:0] {
    CH_R = 2'b00,
    CH_G = 2'b01,
    CH_B = 2'b10
  } chan_t;

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  chan_t       state_q, state_d;
  logic [7:0]  cur_level;
  logic [7:0]  next_level;
  logic        step_up, step_dn;
  logic [15:0] ps_cnt_q;
  logic        tick;
  logic [7:0]  phase_q;
  logic [7:0]  shadow_r_q, shadow_g_q, shadow_b_q;

  function automatic logic [7:0] bcd_succ(input logic [7:0] v);
    logic [3:0] u;
    logic [3:0] t;
    u = v[3:0];
    t = v[7:4];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_pred(input logic [7:0] v);
    logic [3:0] u;
    logic [3:0] t;
    u = v[3:0];
    t = v[7:4];
    if (u == 4'd0) begin
      u = 4'd9;
      t = (t == 4'd0) ? 4'd9 : t - 4'd1;
    end else begin
      u = u - 4'd1;
    end
    return {t, u};
  endfunction

  // Channel selector: the unused code 2'b11 falls back to R.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= CH_R;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sel) begin
      case (state_q)
        CH_R:    state_d = CH_G;
        CH_G:    state_d = CH_B;
        CH_B:    state_d = CH_R;
        default: state_d = CH_R;
      endcase
    end
  end

  assign chan = state_q;

  // Step decision uses the channel active before the edge, so sel+inc steps the old channel.
  always_comb begin
    cur_level = 8'h00;
    case (state_q)
      CH_R:    cur_level = level_r;
      CH_G:    cur_level = level_g;
      CH_B:    cur_level = level_b;
      default: cur_level = 8'h00;
    endcase
    step_up    = inc && !dec && (cur_level < LEVEL_MAX);
    step_dn    = dec && !inc && (cur_level != 8'h00);
    next_level = step_up ? bcd_succ(cur_level) : bcd_pred(cur_level);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      level_r <= 8'h00;
      level_g <= 8'h00;
      level_b <= 8'h00;
    end else if (step_up || step_dn) begin
      case (state_q)
        CH_R:    level_r <= next_level;
        CH_G:    level_g <= next_level;
        CH_B:    level_b <= next_level;
        default: ;
      endcase
    end
  end

  assign tick = (ps_cnt_q == PS_LAST);

  always_ff @(posedge CLK) begin
    if (RST)       ps_cnt_q <= 16'd0;
    else if (tick) ps_cnt_q <= 16'd0;
    else           ps_cnt_q <= ps_cnt_q + 16'd1;
  end

  // Phase runs 00..99 in BCD; the successor of 99 is 00.
  always_ff @(posedge CLK) begin
    if (RST)       phase_q <= 8'h00;
    else if (tick) phase_q <= bcd_succ(phase_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_r_q <= 8'h00;
      shadow_g_q <= 8'h00;
      shadow_b_q <= 8'h00;
    end else if (tick && (phase_q == 8'h99)) begin
      shadow_r_q <= level_r;
      shadow_g_q <= level_g;
      shadow_b_q <= level_b;
    end
  end

  // BCD values order the same as plain unsigned bytes, so a binary compare suffices.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_r <= 1'b0;
      pwm_g <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      pwm_r <= (phase_q < shadow_r_q);
      pwm_g <= (phase_q < shadow_g_q);
      pwm_b <= (phase_q < shadow_b_q);
    end
  end

endmodule

// File: tb/tb_rgb_level_pwm.sv
// tb/tb_rgb_level_pwm.sv - directed bench for rgb_level_pwm at PRESCALE 1 and 4
// Both instances share stimulus; PWM timing is judged on the instance whose prescale fits the case.
module tb_rgb_level_pwm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       sel = 1'b0;

  logic [1:0] chan1, chan4;
  logic [7:0] lr1, lg1, lb1, lr4, lg4, lb4;
  logic       pr1, pg1, pb1, pr4, pg4, pb4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  rgb_level_pwm #(.PRESCALE(1), .LEVEL_MAX(8'h99)) dut1 (
    .CLK(CLK), .RST(RST), .inc(inc), .dec(dec), .sel(sel),
    .chan(chan1), .level_r(lr1), .level_g(lg1), .level_b(lb1),
    .pwm_r(pr1), .pwm_g(pg1), .pwm_b(pb1)
  );

  rgb_level_pwm #(.PRESCALE(4), .LEVEL_MAX(8'h99)) dut4 (
    .CLK(CLK), .RST(RST), .inc(inc), .dec(dec), .sel(sel),
    .chan(chan4), .level_r(lr4), .level_g(lg4), .level_b(lb4),
    .pwm_r(pr4), .pwm_g(pg4), .pwm_b(pb4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic cyc(input logic i, input logic d, input logic s);
    @(negedge CLK);
    inc = i;
    dec = d;
    sel = s;
  endtask

  task automatic pulse(input logic i, input logic d, input logic s);
    cyc(i, d, s);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_chan"}, {chan1, chan4}, 4'h0);
    check({tag, "_lvl1"}, {lr1, lg1, lb1}, 24'h0);
    check({tag, "_lvl4"}, {lr4, lg4, lb4}, 24'h0);
    check({tag, "_pwm"}, {pr1, pg1, pb1, pr4, pg4, pb4}, 6'h0);
  endtask

  initial begin
    int v;
    int cnt, cnt_r, cnt_all;
    logic prev;
    logic found;

    // Reset must override concurrent inc and sel.
    RST = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check_all_reset("reset");
    @(negedge CLK);
    RST = 1'b0;

    repeat (12) pulse(1'b1, 1'b0, 1'b0);
    check("inc12_r", lr1, 8'h12);
    check("inc12_gb", {lg1, lb1}, 16'h0000);
    check("inc12_chan", chan1, 2'b00);
    check("inc12_r4", lr4, 8'h12);

    repeat (86) pulse(1'b1, 1'b0, 1'b0);
    check("to98", lr1, 8'h98);
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0, 1'b0);
      check($sformatf("sat99_%0d", k), lr1, 8'h99);
    end

    v = 99;
    for (int k = 0; k < 100; k++) begin
      pulse(1'b0, 1'b1, 1'b0);
      if (v > 0) v--;
      check($sformatf("dec_%0d", k), lr1, to_bcd(v));
    end

    pulse(1'b0, 1'b0, 1'b1);
    check("sel1", chan1, 2'b01);
    pulse(1'b0, 1'b0, 1'b1);
    check("sel2", chan1, 2'b10);
    pulse(1'b0, 1'b0, 1'b1);
    check("sel3", chan1, 2'b00);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b1);
    check("selinc_g", lg1, 8'h01);
    check("selinc_chan", chan1, 2'b10);
    check("selinc_rb", {lr1, lb1}, 16'h0000);

    pulse(1'b1, 1'b1, 1'b0);
    check("incdec_lvls", {lr1, lg1, lb1}, 24'h000100);
    check("incdec_chan", chan1, 2'b10);

    // level_b=01 for the PRESCALE=4 case, then level_g=25.
    pulse(1'b1, 1'b0, 1'b0);
    check("lb01", lb1, 8'h01);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (24) pulse(1'b1, 1'b0, 1'b0);
    check("lg25", lg1, 8'h25);
    repeat (200) cyc(1'b0, 1'b0, 1'b0);

    // Align to a period start: pwm_g rises only when phase wraps to 00.
    found = 1'b0;
    prev = pg1;
    for (int k = 0; k < 250 && !found; k++) begin
      @(negedge CLK);
      if (!prev && pg1) found = 1'b1;
      prev = pg1;
    end
    check("g_rise_found", found, 1'b1);

    cnt = 1;
    cnt_r = pr1;
    for (int i = 1; i < 100; i++) begin
      cyc((i >= 10 && i < 35), 1'b0, 1'b0);
      cnt += pg1;
      cnt_r += pr1;
    end
    check("g_duty25", cnt, 25);
    check("r_duty0", cnt_r, 0);
    check("lg50", lg1, 8'h50);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cnt += pg1;
    end
    check("g_duty50", cnt, 50);

    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cnt += pb4;
    end
    check("b4_duty1", cnt, 4);

    found = 1'b0;
    prev = pb4;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge CLK);
      if (!prev && pb4) found = 1'b1;
      prev = pb4;
    end
    check("b4_rise_found", found, 1'b1);
    repeat (160) cyc(1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check_all_reset("midrst");
    RST = 1'b0;

    cnt_all = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      cnt_all += pr1 + pg1 + pb1 + pr4 + pg4 + pb4;
    end
    check("post_rst_dark", cnt_all, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_level_pwm.md
RGB_LEVEL_PWM -- requirements
Module: rgb_level_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 1: CLK cycles per PWM phase step; legal range 1..65535.
REQ-002 SHALL have parameter LEVEL_MAX, default 'h99: BCD saturation ceiling for every channel level.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port inc  input  1  single-cycle step-up pulse, as produced by the rotary decoder.
REQ-006 SHALL have port dec  input  1  single-cycle step-down pulse, as produced by the rotary decoder.
REQ-007 SHALL have port sel  input  1  single-cycle pulse from the debounced, edge-detected push button; advances the active channel.
REQ-008 SHALL have port chan  output  2  active channel: 2'b00 R, 2'b01 G, 2'b10 B.
REQ-009 SHALL have ports level_r, level_g, level_b  output  8 each  current BCD level, 00..LEVEL_MAX.
REQ-010 SHALL have ports pwm_r, pwm_g, pwm_b  output  1 each  registered PWM drive to the LED.

Function
REQ-011 Channel FSM SHALL have states R, G, B; on sel: R->G, G->B, B->R; no sel: hold. Code 2'b11 SHALL never be entered.
REQ-012 On inc (dec low), the level of the active channel SHALL take its BCD successor on the next edge: units 9 carries into tens, units become 0.
REQ-013 On dec (inc low), the level of the active channel SHALL take its BCD predecessor on the next edge: units 0 borrows from tens, units become 9.
REQ-014 inc at LEVEL_MAX SHALL leave the level unchanged; dec at 00 SHALL leave the level unchanged. Neither case wraps.
REQ-015 inc and dec high in the same cycle SHALL be ignored; no level changes.
REQ-016 sel together with inc or dec SHALL apply the step to the channel active before the edge; chan advances on the same edge.
REQ-017 Inactive channel levels SHALL never change.
REQ-018 level_* and chan SHALL be direct register outputs, with 1-cycle latency from input pulse to visible change.
REQ-019 Prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick is asserted in the cycle the count equals PRESCALE-1. With PRESCALE=1, tick is asserted every cycle.
REQ-020 Phase counter SHALL be 8-bit BCD, 00..99, advance by one BCD step on tick, and wrap 99->00.
REQ-021 Each channel SHALL have a shadow level, loaded from its level register on the edge where tick is asserted and phase==99 (period boundary). At all other edges the shadow SHALL hold.
REQ-022 pwm_x SHALL be registered as (phase < shadow_x), compared as 8-bit unsigned (valid for BCD), and SHALL lag phase by 1 cycle.
REQ-023 Duty SHALL equal shadow/100 per 100-step period: level 00 gives pwm constantly low; level 99 gives pwm low for exactly 1 phase step per period.
REQ-024 A level change mid-period SHALL NOT alter the current period; the new duty SHALL appear from the next period start.
REQ-025 All arithmetic SHALL use width-exact nibble operations; no BCD digit shall ever hold A-F.

Reset
REQ-026 RST high at an edge SHALL set chan=R, every level=00, every shadow=00, phase=00, prescaler=0 and every pwm=0, overriding inc, dec and sel in that cycle.
REQ-027 Reset asserted mid-period SHALL abandon the period; after release the first period SHALL start at phase 00 with all duties 0.
REQ-028 Outputs SHALL be defined (not X) from the first edge with RST high.

Verification
REQ-029 Reset, then 12 inc pulses on R -> level_r=12, level_g=level_b=00, chan=00.
REQ-030 Set level_r=98, then 3 inc pulses -> 99, 99, 99. Then 100 dec pulses -> level_r=00, with no wrap at any step.
REQ-031 2 sel pulses, then 1 more -> chan 01, 10, then 00. A sel and inc in the same cycle while chan=01 -> level_g+1 and chan=10.
REQ-032 inc and dec in the same cycle -> all levels unchanged.
REQ-033 PRESCALE=1, level_g=25 latched at the boundary -> pwm_g high for exactly 25 of every 100 cycles. Raising level_g to 50 mid-period -> the remainder of that period still shows 25; the next period shows 50.
REQ-034 PRESCALE=4, level_b=01 -> pwm_b high for 4 of every 400 cycles. Assert RST at phase 40 -> pwm_b=0 next cycle, with all levels and chan reset.
